// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state/instruction kinds,
// class and opcode encodings, and a generic bit-field extractor.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_T1,
        ST_T2,
        ST_T3,
        ST_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_LOAD,
        K_COPY,
        K_ALU,
        K_ADDI,
        K_SUBI,
        K_HALT,
        K_ILLEGAL
    } kind_t;

    localparam logic [1:0] CLS_REG  = 2'b00;
    localparam logic [1:0] CLS_ADDI = 2'b01;
    localparam logic [1:0] CLS_RSVD = 2'b10;
    localparam logic [1:0] CLS_SUBI = 2'b11;

    localparam logic [3:0] OP_LOAD   = 4'b0000;
    localparam logic [3:0] OP_COPY   = 4'b0001;
    localparam logic [3:0] OP_ALU_LO = 4'b0010;
    localparam logic [3:0] OP_ALU_HI = 4'b1011;
    localparam logic [3:0] OP_HALT   = 4'b1111;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0011;

    // Returns word[lsb +: width], zero-extended; callers cast to the field width.
    function automatic logic [31:0] get_field(input logic [63:0] word, input int lsb,
                                              input int width);
        logic [63:0] mask;
        mask = ~(64'hFFFF_FFFF_FFFF_FFFF << width);
        return 32'((word >> lsb) & mask);
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decode: classifies ir and extracts Rx, Ry, opcode and
// the zero-extended immediate.
module seq_decode
    import seq_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 2,
    parameter int OP_W       = 4,
    parameter int DATA_W     = 2 + OP_W + 2 * REG_ADDR_W,
    parameter int IMM_W      = OP_W + REG_ADDR_W
) (
    input  logic [DATA_W-1:0]     ir,
    output kind_t                 kind,
    output logic [REG_ADDR_W-1:0] rx,
    output logic [REG_ADDR_W-1:0] ry,
    output logic [OP_W-1:0]       op,
    output logic [DATA_W-1:0]     imm
);

    always_comb begin
        op   = OP_W'(get_field(64'(ir), 2, OP_W));
        ry   = REG_ADDR_W'(get_field(64'(ir), 2 + OP_W, REG_ADDR_W));
        rx   = REG_ADDR_W'(get_field(64'(ir), DATA_W - REG_ADDR_W, REG_ADDR_W));
        imm  = DATA_W'(get_field(64'(ir), 2, IMM_W));
        kind = K_ILLEGAL;
        case (ir[1:0])
            CLS_ADDI: kind = K_ADDI;
            CLS_SUBI: kind = K_SUBI;
            CLS_RSVD: kind = K_ILLEGAL;
            CLS_REG: begin
                if (op == OP_W'(OP_LOAD))
                    kind = K_LOAD;
                else if (op == OP_W'(OP_COPY))
                    kind = K_COPY;
                else if (op == OP_W'(OP_HALT))
                    kind = K_HALT;
                else if (op >= OP_W'(OP_ALU_LO) && op <= OP_W'(OP_ALU_HI))
                    kind = K_ALU;
                else
                    kind = K_ILLEGAL;
            end
            default: kind = K_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle timestep sequencer driving the shared-bus datapath enables.
//   state | meaning
//   IDLE  | waiting for run, nothing driven
//   FETCH | load IR from the external data port
//   T1-T3 | instruction timesteps, outputs decoded from ir
//   HALT  | HALT executed, parked until run drops
module seq_controller
    import seq_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = 2,
    parameter int OP_W       = 4,
    parameter int DATA_W     = 2 + OP_W + 2 * REG_ADDR_W,
    parameter int IMM_W      = OP_W + REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [DATA_W-1:0]     ir,
    output logic                  ir_in,
    output logic                  ext,
    output logic [DATA_W-1:0]     imm,
    output logic                  imm_out,
    output logic [REG_ADDR_W-1:0] rin,
    output logic [REG_ADDR_W-1:0] rout,
    output logic                  enw,
    output logic                  enr,
    output logic                  ain,
    output logic                  gin,
    output logic                  gout,
    output logic [OP_W-1:0]       alu_op,
    output logic                  busy,
    output logic                  done,
    output logic                  illegal,
    output logic                  halted
);

    if (DATA_W != 2 + OP_W + 2 * REG_ADDR_W) begin : g_bad_data_w
        $error("seq_controller: DATA_W must equal 2+OP_W+2*REG_ADDR_W");
    end

    state_t                state;
    kind_t                 kind;
    logic [REG_ADDR_W-1:0] rx, ry;
    logic [OP_W-1:0]       op;
    logic [DATA_W-1:0]     imm_val;

    seq_decode #(
        .REG_ADDR_W (REG_ADDR_W),
        .OP_W       (OP_W),
        .DATA_W     (DATA_W),
        .IMM_W      (IMM_W)
    ) u_decode (
        .ir   (ir),
        .kind (kind),
        .rx   (rx),
        .ry   (ry),
        .op   (op),
        .imm  (imm_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (run) state <= ST_FETCH;
                ST_FETCH: state <= ST_T1;
                ST_T1: begin
                    case (kind)
                        K_ALU, K_ADDI, K_SUBI: state <= ST_T2;
                        K_HALT:                state <= ST_HALT;
                        default:               state <= run ? ST_FETCH : ST_IDLE;
                    endcase
                end
                ST_T2:    state <= ST_T3;
                ST_T3:    state <= run ? ST_FETCH : ST_IDLE;
                ST_HALT:  if (!run) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // ADDI/SUBI reuse the ALU path with the immediate loaded into A in T1.
    always_comb begin
        ir_in   = 1'b0;
        ext     = 1'b0;
        imm     = '0;
        imm_out = 1'b0;
        rin     = '0;
        rout    = '0;
        enw     = 1'b0;
        enr     = 1'b0;
        ain     = 1'b0;
        gin     = 1'b0;
        gout    = 1'b0;
        alu_op  = '0;
        done    = 1'b0;
        illegal = 1'b0;
        busy    = (state != ST_IDLE) && (state != ST_HALT);
        halted  = (state == ST_HALT);
        case (state)
            ST_FETCH: begin
                ir_in = 1'b1;
                ext   = 1'b1;
            end
            ST_T1: begin
                case (kind)
                    K_LOAD: begin
                        ext  = 1'b1;
                        enw  = 1'b1;
                        rin  = rx;
                        done = 1'b1;
                    end
                    K_COPY: begin
                        enr  = 1'b1;
                        rout = ry;
                        enw  = 1'b1;
                        rin  = rx;
                        done = 1'b1;
                    end
                    K_ALU: begin
                        enr  = 1'b1;
                        rout = ry;
                        ain  = 1'b1;
                    end
                    K_ADDI, K_SUBI: begin
                        imm     = imm_val;
                        imm_out = 1'b1;
                        ain     = 1'b1;
                    end
                    K_HALT: done = 1'b1;
                    default: begin
                        illegal = 1'b1;
                        done    = 1'b1;
                    end
                endcase
            end
            ST_T2: begin
                enr  = 1'b1;
                rout = rx;
                gin  = 1'b1;
                case (kind)
                    K_ADDI:  alu_op = OP_W'(ALU_ADD);
                    K_SUBI:  alu_op = OP_W'(ALU_SUB);
                    default: alu_op = op;
                endcase
            end
            ST_T3: begin
                gout = 1'b1;
                enw  = 1'b1;
                rin  = rx;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_controller.sv
// Scoreboard bench for seq_controller: each cycle's expected output vector is queued
// when the stimulus for that cycle is applied and compared on the falling edge.
module tb_seq_controller;

    typedef struct packed {
        logic       ir_in;
        logic       ext;
        logic [9:0] imm;
        logic       imm_out;
        logic [1:0] rin;
        logic [1:0] rout;
        logic       enw;
        logic       enr;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu_op;
        logic       busy;
        logic       done;
        logic       illegal;
        logic       halted;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [9:0] ir;
    logic       ir_in, ext, imm_out, enw, enr, ain, gin, gout, busy, done, illegal, halted;
    logic [9:0] imm;
    logic [1:0] rin, rout;
    logic [3:0] alu_op;
    ov_t        obs;

    int   n_checks = 0;
    int   n_fail   = 0;
    ov_t   sb[$];
    string tq[$];

    seq_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .ir      (ir),
        .ir_in   (ir_in),
        .ext     (ext),
        .imm     (imm),
        .imm_out (imm_out),
        .rin     (rin),
        .rout    (rout),
        .enw     (enw),
        .enr     (enr),
        .ain     (ain),
        .gin     (gin),
        .gout    (gout),
        .alu_op  (alu_op),
        .busy    (busy),
        .done    (done),
        .illegal (illegal),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    assign obs = {ir_in, ext, imm, imm_out, rin, rout, enw, enr, ain, gin, gout,
                  alu_op, busy, done, illegal, halted};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_compare();
        ov_t   e;
        string t;
        e = sb.pop_front();
        t = tq.pop_front();
        check_val(t, 32'(obs), 32'(e));
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) sb_compare();
    end

    // Queue the expectation for the current cycle, then advance to just after the next edge.
    task automatic tick(input string tag, input ov_t e);
        sb.push_back(e);
        tq.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    function automatic ov_t e_idle();
        ov_t e = '0;
        return e;
    endfunction

    function automatic ov_t e_fetch();
        ov_t e = '0;
        e.ir_in = 1'b1; e.ext = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_load(input logic [1:0] rx);
        ov_t e = '0;
        e.ext = 1'b1; e.enw = 1'b1; e.rin = rx; e.done = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_copy(input logic [1:0] rx, input logic [1:0] ry);
        ov_t e = '0;
        e.enr = 1'b1; e.rout = ry; e.enw = 1'b1; e.rin = rx; e.done = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_alu1(input logic [1:0] ry);
        ov_t e = '0;
        e.enr = 1'b1; e.rout = ry; e.ain = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_imm1(input logic [9:0] v);
        ov_t e = '0;
        e.imm = v; e.imm_out = 1'b1; e.ain = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_alu2(input logic [1:0] rx, input logic [3:0] op);
        ov_t e = '0;
        e.enr = 1'b1; e.rout = rx; e.gin = 1'b1; e.alu_op = op; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_wb(input logic [1:0] rx);
        ov_t e = '0;
        e.gout = 1'b1; e.enw = 1'b1; e.rin = rx; e.done = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_ill();
        ov_t e = '0;
        e.illegal = 1'b1; e.done = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_halt1();
        ov_t e = '0;
        e.done = 1'b1; e.busy = 1'b1;
        return e;
    endfunction

    function automatic ov_t e_halted();
        ov_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        run   = 1'b1;
        ir    = 10'h000;
        @(posedge clk);
        #1;
        tick("reset_hold0", e_idle());
        tick("reset_hold1", e_idle());
        rst_n = 1'b1;
        tick("idle_release", e_idle());

        // LOAD R0
        tick("load_fetch", e_fetch());
        tick("load_t1", e_load(2'd0));

        // ALU add Rx=2 Ry=1, back-to-back after LOAD
        ir = 10'h248;
        tick("alu_fetch", e_fetch());
        tick("alu_t1", e_alu1(2'd1));
        tick("alu_t2", e_alu2(2'd2, 4'b0010));
        tick("alu_t3", e_wb(2'd2));

        // SUBI Rx=1 imm=5
        ir = 10'h117;
        tick("subi_fetch", e_fetch());
        tick("subi_t1", e_imm1(10'h005));
        tick("subi_t2", e_alu2(2'd1, 4'b0011));
        tick("subi_t3", e_wb(2'd1));

        // ADDI Rx=3 imm=0x2A (widest immediate pattern)
        ir = 10'h3A9;
        tick("addi_fetch", e_fetch());
        tick("addi_t1", e_imm1(10'h02A));
        tick("addi_t2", e_alu2(2'd3, 4'b0010));
        tick("addi_t3", e_wb(2'd3));

        // COPY Rx=3 Ry=2
        ir = 10'h384;
        tick("copy_fetch", e_fetch());
        tick("copy_t1", e_copy(2'd3, 2'd2));

        // ALU top opcode 1011, Rx=0 Ry=3
        ir = 10'h0EC;
        tick("alu_hi_fetch", e_fetch());
        tick("alu_hi_t1", e_alu1(2'd3));
        tick("alu_hi_t2", e_alu2(2'd0, 4'b1011));
        tick("alu_hi_t3", e_wb(2'd0));

        // Illegal encodings: class 10, op 1101, op 1100
        ir = 10'h002;
        tick("ill_cls_fetch", e_fetch());
        tick("ill_cls_t1", e_ill());
        ir = 10'h034;
        tick("ill_op13_fetch", e_fetch());
        tick("ill_op13_t1", e_ill());
        ir = 10'h030;
        tick("ill_op12_fetch", e_fetch());
        tick("ill_op12_t1", e_ill());

        // HALT with run held high, then release
        ir = 10'h03C;
        tick("halt_fetch", e_fetch());
        tick("halt_t1", e_halt1());
        for (int i = 0; i < 10; i++) tick("halted_hold", e_halted());
        run = 1'b0;
        tick("halted_drop", e_halted());
        tick("halt_idle0", e_idle());
        tick("halt_idle1", e_idle());
        run = 1'b1;
        tick("halt_idle_run", e_idle());

        // Drop run during T1 of an ALU op: instruction completes, then IDLE
        ir = 10'h248;
        tick("drop_fetch", e_fetch());
        run = 1'b0;
        tick("drop_t1", e_alu1(2'd1));
        tick("drop_t2", e_alu2(2'd2, 4'b0010));
        tick("drop_t3", e_wb(2'd2));
        tick("drop_idle0", e_idle());
        tick("drop_idle1", e_idle());
        run = 1'b1;
        tick("rerun_idle", e_idle());

        // LOAD R1 then ALU interrupted by reset in T2
        ir = 10'h100;
        tick("load1_fetch", e_fetch());
        tick("load1_t1", e_load(2'd1));
        ir = 10'h248;
        tick("rst_fetch", e_fetch());
        tick("rst_t1", e_alu1(2'd1));
        sb.push_back(e_alu2(2'd2, 4'b0010));
        tq.push_back("rst_t2_pre");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        sb.push_back(e_idle());
        tq.push_back("rst_async_zero");
        sb_compare();
        @(posedge clk);
        #1;
        tick("rst_hold", e_idle());
        rst_n = 1'b1;
        tick("rst_release0", e_idle());
        tick("rst_release1", e_idle());
        tick("rst_release2", e_idle());

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_controller.md
# seq_controller

Parametrised multi-cycle control sequencer for the shared-bus datapath: register file, ALU staging registers A/G, instruction register, external data port. Successor to the current controller. Owns its own timestep state machine instead of taking an external counter, and generalises data, register-address and opcode widths. Adds a run/idle handshake, a HALT instruction, illegal-instruction reporting and a bus-driving immediate path. Sits between the instruction register and the datapath enables.

## Interface
Parameters:
- `REG_ADDR_W`, 2: register-address width (2^REG_ADDR_W registers).
- `OP_W`, 4: opcode and ALU-control width.
- `DATA_W`, 2+OP_W+2*REG_ADDR_W (=10): instruction and bus width. Any other value is an elaboration error.
- `IMM_W`, OP_W+REG_ADDR_W (=6): immediate field width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `run` in 1: level; permits fetching.
- `ir` in DATA_W: instruction register contents.
- `ir_in` out 1: load IR from bus.
- `ext` out 1: drive bus from external data.
- `imm` out DATA_W: immediate value.
- `imm_out` out 1: drive bus from `imm`.
- `rin` out REG_ADDR_W: write address.
- `rout` out REG_ADDR_W: read address.
- `enw` out 1, `enr` out 1: register-file write and read enables.
- `ain` out 1, `gin` out 1, `gout` out 1: A load, G load, G drives bus.
- `alu_op` out OP_W: ALU control.
- `busy` out 1: asserted in every state except IDLE and HALT.
- `done` out 1: one-cycle pulse on an instruction's final step.
- `illegal` out 1: one-cycle pulse on an undefined encoding.
- `halted` out 1: high in HALT.

## Operation
- Fields: class = `ir[1:0]`; op = `ir[OP_W+1:2]`; Ry = next REG_ADDR_W bits above op; Rx = top REG_ADDR_W bits; immediate field = `ir[IMM_W+1:2]`.
- States: IDLE, FETCH, T1, T2, T3, HALT.
- All outputs are 0 unless listed below. No output is ever X or Z.
- IDLE: nothing is driven. If `run`=1, go to FETCH.
- FETCH: `ir_in`=1, `ext`=1. Go to T1. IR is valid from T1 onward.
- Class 00, op 0000 LOAD:
  - T1: `ext`, `enw`, `rin`=Rx, `done`.
- Class 00, op 0001 COPY:
  - T1: `enr`, `rout`=Ry, `enw`, `rin`=Rx, `done`.
- Class 00, op 0010–1011 ALU:
  - T1: `enr`, `rout`=Ry, `ain`.
  - T2: `enr`, `rout`=Rx, `gin`, `alu_op`=op.
  - T3: `gout`, `enw`, `rin`=Rx, `done`.
- Class 01 ADDI and class 11 SUBI:
  - T1: `imm`=zero-extended immediate field, `imm_out`, `ain`.
  - T2: `enr`, `rout`=Rx, `gin`, `alu_op`=ALU_ADD (ADDI) or ALU_SUB (SUBI).
  - T3: `gout`, `enw`, `rin`=Rx, `done`.
- Class 00, op 1111 HALT:
  - T1: `done`. Go to HALT.
  - HALT: `halted`=1. Leave to IDLE only when `run`=0.
- Class 10, or class 00 with op 1100–1110: T1 pulses `illegal` with no enables, then follows the `done` transition rule.
- `done` transition rule: go to FETCH if `run`=1, else IDLE. Dropping `run` mid-instruction completes that instruction first.

## Timing
- State register only. Outputs are combinational from state and `ir`.
- Latency from FETCH: LOAD, COPY, HALT and illegal take 2 cycles. ALU, ADDI and SUBI take 4.
- Back-to-back: FETCH follows the `done` cycle directly, with no bubble.
- Reset: state becomes IDLE asynchronously and every output is 0 immediately, including mid-instruction and in HALT. Release is synchronous to the next edge.
- `ir` is sampled combinationally in T1–T3. It must hold stable from the end of FETCH until `done`.
- `run` is sampled only in IDLE, HALT and on `done` cycles.

## Structure
- Package `seq_ctrl_pkg`:
  - state enum;
  - class codes;
  - opcode constants OP_LOAD, OP_COPY, OP_HALT, OP_ALU_LO, OP_ALU_HI;
  - ALU_ADD=4'b0010, ALU_SUB=4'b0011;
  - field-extraction functions.
- One natural sub-module, `seq_decode`. It is combinational and maps `ir` to an instruction kind plus Rx/Ry/immediate. The FSM and output logic stay in `seq_controller`.

## Test plan
- Reset held, `run`=1 → all outputs 0, `busy`=0. Release with `ir`=0x000 (LOAD R0) → FETCH (`ir_in`, `ext`), then T1 with `ext`, `enw`, `rin`=0, `done`. Next cycle is FETCH.
- ALU `ir`=0b10_01_0010_00 (Rx=2, Ry=1, ALU_ADD) → T1 `rout`=1 + `ain`; T2 `rout`=2 + `gin` + `alu_op`=0010; T3 `gout`, `enw`, `rin`=2, `done`.
- SUBI `ir`=0b01_000101_11 → T1 `imm`=0x005 + `imm_out` + `ain`; T2 `alu_op`=ALU_SUB + `rout`=1; T3 `rin`=1, `done`.
- Class 10 `ir`=0x002, then op 1101 → a single-cycle `illegal` pulse each time, no enables, back to FETCH.
- HALT `ir`=0b00_00_1111_00 with `run`=1 → `halted` stays high for 10 cycles. Drop `run` → IDLE. Reassert → FETCH.
- Assert `rst_n`=0 during T2 of an ALU op → outputs 0 in the same cycle. After release, IDLE, with no `done` pulse.
